comparator_arbiter: RTL and testbench

- Shares one WIDTH-bit magnitude comparator between two requesters, e.g. branch unit (port 0) and SLT/SLTU unit (port 1).
- Round-robin arbitration, operand capture, signed/unsigned selection and a registered one-cycle result pulse to the granted requester.
- Sits between the execute-stage consumers and the shared comparator datapath.

---
 rtl/comparator_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_comparator_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_arbiter.sv
// -----------------------------------------------------------------------------
// comparator_arbiter
//
// Two execute-stage requesters share one WIDTH-bit magnitude comparator. For
// example, port 0 is the branch unit and port 1 is the SLT/SLTU unit.
//
// Operation:
//   - A round-robin arbiter picks one requester when the block is idle.
//   - The winner's operands and signed flag are captured.
//   - One cycle later the comparison result is returned to the winner as a
//     registered one-cycle pulse.
//   - Throughput is one comparison every three cycles (IDLE -> CMP -> RESP).
//
// Ports:
//   clk_i              clock, all state updates on the rising edge
//   rst_i              synchronous, active-high reset
//   req_i[1:0]         request per requester (bit k = requester k)
//   a0_i, b0_i         operands A/B of requester 0
//   a1_i, b1_i         operands A/B of requester 1
//   signed_i[1:0]      bit k = 1: requester k's operands are two's complement
//   gnt_o[1:0]         one-hot, one-cycle grant pulse (operands captured)
//   valid_o[1:0]       one-hot, one-cycle result-valid pulse to the owner
//   greater_o          A >  B, qualified by valid_o != 0
//   equal_o            A == B, qualified by valid_o != 0
//   lesser_o           A <  B, qualified by valid_o != 0
//   busy_o             high while a transaction occupies CMP or RESP
// -----------------------------------------------------------------------------
module comparator_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  input  logic [1:0]       signed_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       valid_o,
  output logic             greater_o,
  output logic             equal_o,
  output logic             lesser_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;

  // Arbitration and capture state.
  // r_prio names the requester that wins a tie.
  logic             r_prio;
  logic             r_owner;
  logic             r_signed;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Registered outputs.
  logic [1:0]       r_gnt;
  logic [1:0]       r_valid;
  logic             r_greater;
  logic             r_equal;
  logic             r_lesser;
  logic             r_busy;

  // Arbitration wires.
  logic             w_start;
  logic             w_win;
  logic [WIDTH-1:0] w_win_a;
  logic [WIDTH-1:0] w_win_b;
  logic             w_win_signed;

  // Comparator wires.
  logic [WIDTH-1:0] w_a_cmp;
  logic [WIDTH-1:0] w_b_cmp;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;

  // Next values of the registered outputs.
  logic [1:0]       w_gnt_nxt;
  logic [1:0]       w_valid_nxt;
  logic             w_greater_nxt;
  logic             w_equal_nxt;
  logic             w_lesser_nxt;
  logic             w_busy_nxt;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // Requests are only looked at in IDLE.
  // In CMP and RESP, req_i is ignored entirely.
  assign w_start = (r_state == S_IDLE) && (req_i != 2'b00);

  // A single requester always wins.
  // On a tie, the priority pointer decides.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves a variable unassigned would otherwise infer a latch.
    w_win = 1'b0;
    unique case (req_i)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = r_prio;
      default: w_win = 1'b0;
    endcase
  end

  assign w_win_a      = w_win ? a1_i : a0_i;
  assign w_win_b      = w_win ? b1_i : b0_i;
  assign w_win_signed = w_win ? signed_i[1] : signed_i[0];

  // ---------------------------------------------------------------------------
  // Shared comparator
  // ---------------------------------------------------------------------------
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  // One unsigned comparator therefore serves both signed and unsigned modes.
  assign w_a_cmp = {r_a[WIDTH-1] ^ r_signed, r_a[WIDTH-2:0]};
  assign w_b_cmp = {r_b[WIDTH-1] ^ r_signed, r_b[WIDTH-2:0]};

  assign w_gt = (w_a_cmp > w_b_cmp);
  assign w_eq = (r_a == r_b);
  assign w_lt = (w_a_cmp < w_b_cmp);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_CMP;
      S_CMP:   w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_gnt_nxt     = 2'b00;
    w_valid_nxt   = 2'b00;
    w_greater_nxt = 1'b0;
    w_equal_nxt   = 1'b0;
    w_lesser_nxt  = 1'b0;
    w_busy_nxt    = (w_state_nxt != S_IDLE);

    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_gnt_nxt = w_win ? 2'b10 : 2'b01;
        end
      end
      S_CMP: begin
        w_valid_nxt   = r_owner ? 2'b10 : 2'b01;
        w_greater_nxt = w_gt;
        w_equal_nxt   = w_eq;
        w_lesser_nxt  = w_lt;
      end
      default: begin
        // RESP (and any illegal encoding) drives all pulses low.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture registers and priority pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: the operand registers are reset as well as the control state.
    // After reset, every observable and internal value is then a known
    // constant rather than a leftover from the aborted transaction.
    if (rst_i) begin
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_signed <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
    end else if (w_start) begin
      r_owner  <= w_win;
      r_signed <= w_win_signed;
      r_a      <= w_win_a;
      r_b      <= w_win_b;
      // The loser of this round is favoured next time, which makes
      // continuous requests from both ports strictly alternate.
      r_prio   <= ~w_win;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gnt     <= 2'b00;
      r_valid   <= 2'b00;
      r_greater <= 1'b0;
      r_equal   <= 1'b0;
      r_lesser  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_valid   <= w_valid_nxt;
      r_greater <= w_greater_nxt;
      r_equal   <= w_equal_nxt;
      r_lesser  <= w_lesser_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign gnt_o     = r_gnt;
  assign valid_o   = r_valid;
  assign greater_o = r_greater;
  assign equal_o   = r_equal;
  assign lesser_o  = r_lesser;
  assign busy_o    = r_busy;

  // ---------------------------------------------------------------------------
  // Interface invariants
  // ---------------------------------------------------------------------------
  a_gnt_onehot0 : assert property (@(posedge clk_i) $onehot0(gnt_o));

  a_valid_onehot0 : assert property (@(posedge clk_i) $onehot0(valid_o));

  a_flags_onehot : assert property (
    @(posedge clk_i) (valid_o != 2'b00) |-> $onehot({greater_o, equal_o, lesser_o})
  );

endmodule

// File: tb/tb_comparator_arbiter.sv
// -----------------------------------------------------------------------------
// tb_comparator_arbiter
//
// Directed testbench for comparator_arbiter (WIDTH = 32).
//
// Timing convention:
//   - Inputs are driven 1 ns after a rising edge.
//   - Outputs are sampled at that same point, so each sample shows the
//     registers as updated by the edge just passed.
//
// Flag triples are written {greater, equal, lesser}.
// -----------------------------------------------------------------------------
module tb_comparator_arbiter;

  localparam int WIDTH = 32;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic             clk_i;
  logic             rst_i;
  logic [1:0]       req_i;
  logic [WIDTH-1:0] a0_i;
  logic [WIDTH-1:0] b0_i;
  logic [WIDTH-1:0] a1_i;
  logic [WIDTH-1:0] b1_i;
  logic [1:0]       signed_i;
  logic [1:0]       gnt_o;
  logic [1:0]       valid_o;
  logic             greater_o;
  logic             equal_o;
  logic             lesser_o;
  logic             busy_o;

  int n_checks = 0;
  int n_errors = 0;

  comparator_arbiter #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .a0_i      (a0_i),
    .b0_i      (b0_i),
    .a1_i      (a1_i),
    .b1_i      (b1_i),
    .signed_i  (signed_i),
    .gnt_o     (gnt_o),
    .valid_o   (valid_o),
    .greater_o (greater_o),
    .equal_o   (equal_o),
    .lesser_o  (lesser_o),
    .busy_o    (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Watchdog: stop the run if the stimulus never finishes.
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [2:0] flags();
    return {greater_o, equal_o, lesser_o};
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // One single-port transaction, checked cycle by cycle.
  // If 'scramble' is set, the operands are overwritten right after the grant.
  task automatic single(input string tag, input int port,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [2:0] exp_f,
                        input bit scramble);
    logic [1:0] onehot;
    onehot = (port == 1) ? 2'b10 : 2'b01;

    if (port == 1) begin
      a1_i = a;
      b1_i = b;
    end else begin
      a0_i = a;
      b0_i = b;
    end
    signed_i[port] = sgn;
    req_i = onehot;

    // Request edge: grant pulse, busy rises, no result yet.
    tick();
    check({tag, ".gnt"},   {30'd0, gnt_o},   {30'd0, onehot});
    check({tag, ".busy1"}, {31'd0, busy_o},  32'd1);
    check({tag, ".nov1"},  {30'd0, valid_o}, 32'd0);

    req_i = 2'b00;
    if (scramble) begin
      a0_i = 32'h0000_0000;
      b0_i = 32'hffff_ffff;
      a1_i = 32'h0000_0000;
      b1_i = 32'hffff_ffff;
      signed_i = ~signed_i;
    end

    // CMP -> RESP: result pulse to the owner.
    tick();
    check({tag, ".gnt0"},  {30'd0, gnt_o},   32'd0);
    check({tag, ".valid"}, {30'd0, valid_o}, {30'd0, onehot});
    check({tag, ".flags"}, {29'd0, flags()}, {29'd0, exp_f});
    check({tag, ".busy2"}, {31'd0, busy_o},  32'd1);

    // RESP -> IDLE: everything cleared.
    tick();
    check({tag, ".nov2"},   {30'd0, valid_o}, 32'd0);
    check({tag, ".fclr"},   {29'd0, flags()}, 32'd0);
    check({tag, ".busy0"},  {31'd0, busy_o},  32'd0);
    signed_i = 2'b00;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_i    = 1'b1;
    req_i    = 2'b00;
    a0_i     = '0;
    b0_i     = '0;
    a1_i     = '0;
    b1_i     = '0;
    signed_i = 2'b00;

    tick();
    tick();
    rst_i = 1'b0;

    // Reset state
    check("rst.gnt",   {30'd0, gnt_o},   32'd0);
    check("rst.valid", {30'd0, valid_o}, 32'd0);
    check("rst.flags", {29'd0, flags()}, 32'd0);
    check("rst.busy",  {31'd0, busy_o},  32'd0);

    // Basic single requests
    single("p0_1gt0",   0, 32'h0000_0001, 32'h0000_0000, 1'b0, GT, 1'b0);
    single("p1_unsgn",  1, 32'hfedc_ba98, 32'h1234_5678, 1'b0, GT, 1'b0);
    single("p1_sgn",    1, 32'hfedc_ba98, 32'h1234_5678, 1'b1, LT, 1'b0);

    // Operands changed after the grant: the captured values must win
    single("capture",   0, 32'h0000_0005, 32'h0000_0003, 1'b0, GT, 1'b1);

    // Boundary operand values
    single("zero_eq",   0, 32'h0000_0000, 32'h0000_0000, 1'b0, EQ, 1'b0);
    single("min_sgn",   1, 32'h8000_0000, 32'h7fff_ffff, 1'b1, LT, 1'b0);
    single("min_unsgn", 0, 32'h8000_0000, 32'h7fff_ffff, 1'b0, GT, 1'b0);

    // Fairness: both requesting continuously from reset
    begin
      logic [1:0] exp_gnt [4];
      int n_gnt;
      int n_val;

      exp_gnt[0] = 2'b01;
      exp_gnt[1] = 2'b10;
      exp_gnt[2] = 2'b01;
      exp_gnt[3] = 2'b10;

      do_reset();
      a0_i     = 32'hfedc_ba98;
      b0_i     = 32'hfedc_ba98;
      a1_i     = 32'h1234_5678;
      b1_i     = 32'hfedc_ba98;
      signed_i = 2'b00;
      req_i    = 2'b11;
      n_gnt    = 0;
      n_val    = 0;

      for (int cyc = 0; cyc < 40 && n_gnt < 4; cyc++) begin
        tick();
        check("rr.valid_onehot0", {31'd0, ($countones(valid_o) <= 1)}, 32'd1);

        if (gnt_o != 2'b00) begin
          check($sformatf("rr.gnt%0d", n_gnt), {30'd0, gnt_o}, {30'd0, exp_gnt[n_gnt]});
          req_i = req_i & ~gnt_o;
          n_gnt++;
        end

        if (valid_o != 2'b00) begin
          check($sformatf("rr.flags%0d", n_val), {29'd0, flags()},
                {29'd0, (valid_o == 2'b01) ? EQ : LT});
          req_i = req_i | valid_o;
          n_val++;
        end
      end

      check("rr.grant_count", n_gnt, 4);

      // Drain the last transaction.
      req_i = 2'b00;
      tick();
      tick();
      tick();
    end

    // Reset during CMP discards the transaction and the pointer
    do_reset();
    a0_i     = 32'h0000_0001;
    b0_i     = 32'h0000_0000;
    signed_i = 2'b00;
    req_i    = 2'b01;
    tick();
    check("rstmid.gnt", {30'd0, gnt_o}, 32'd1);  // pointer now favours 1
    req_i = 2'b00;

    rst_i = 1'b1;  // reset lands on the CMP edge
    tick();
    rst_i = 1'b0;
    check("rstmid.valid", {30'd0, valid_o}, 32'd0);
    check("rstmid.gnt0",  {30'd0, gnt_o},   32'd0);
    check("rstmid.flags", {29'd0, flags()}, 32'd0);
    check("rstmid.busy",  {31'd0, busy_o},  32'd0);

    req_i = 2'b11;
    tick();
    check("rstmid.nov",     {30'd0, valid_o}, 32'd0);
    check("rstmid.regrant", {30'd0, gnt_o},   32'd1);
    req_i = 2'b00;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
